// File: rtl/ifetch.sv
// Instruction fetch: one outstanding bus request, one-entry output buffer, redirect squash.
// Best case one instruction per 3 cycles; the buffer is held until decode accepts it.
module ifetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pcplus4,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_exc,
  input  logic        d_ready
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic [63:0] r_req_addr, w_req_addr_nxt;
  logic        r_drop, w_drop_nxt;
  logic [31:0] r_f_instr, w_f_instr_nxt;
  logic        r_f_exc, w_f_exc_nxt;
  logic [63:0] w_pcplus4;
  logic        w_misaligned;

  assign w_pcplus4    = r_pc + 64'd4;
  assign w_misaligned = (r_req_addr[1:0] != 2'b00);

  assign pcplus4    = w_pcplus4;
  assign ireq_valid = (r_state == S_REQ) && !w_misaligned;
  assign ireq_addr  = r_req_addr;
  assign f_valid    = (r_state == S_HOLD);
  assign f_pc       = r_pc;
  assign f_instr    = r_f_instr;
  assign f_exc      = r_f_exc;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_addr_nxt = r_req_addr;
    w_drop_nxt     = r_drop;
    w_f_instr_nxt  = r_f_instr;
    w_f_exc_nxt    = r_f_exc;

    // Redirect outranks the sequential advance on a decode handshake.
    if (redirect_valid) begin
      w_pc_nxt = redirect_pc;
    end else if (r_state == S_HOLD && d_ready) begin
      w_pc_nxt = w_pcplus4;
    end

    case (r_state)
      S_IDLE: begin
        w_state_nxt    = S_REQ;
        w_req_addr_nxt = w_pc_nxt;
      end
      S_REQ: begin
        if (w_misaligned) begin
          w_state_nxt   = S_HOLD;
          w_f_exc_nxt   = 1'b1;
          w_f_instr_nxt = 32'd0;
        end else if (ireq_ready) begin
          w_state_nxt = S_WAIT;
          w_drop_nxt  = r_drop | redirect_valid;
        end else if (redirect_valid) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (iresp_valid) begin
          if (!r_drop && !redirect_valid) begin
            w_state_nxt   = S_HOLD;
            w_f_instr_nxt = iresp_data;
            w_f_exc_nxt   = 1'b0;
          end else begin
            w_state_nxt    = S_REQ;
            w_drop_nxt     = 1'b0;
            w_req_addr_nxt = w_pc_nxt;
          end
        end else if (redirect_valid) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_state_nxt    = S_REQ;
          w_req_addr_nxt = redirect_pc;
        end else if (d_ready) begin
          w_state_nxt    = S_REQ;
          w_req_addr_nxt = w_pcplus4;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_drop     <= 1'b0;
      r_f_instr  <= 32'd0;
      r_f_exc    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_drop     <= w_drop_nxt;
      r_f_instr  <= w_f_instr_nxt;
      r_f_exc    <= w_f_exc_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: inputs change 1ns after a rising edge, outputs are checked there too.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] pcplus4;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        f_exc;
  logic        d_ready;

  int n_pass = 0;
  int n_chk  = 0;

  ifetch #(.RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .resetn(resetn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pcplus4(pcplus4),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_exc(f_exc),
    .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    ireq_ready     = 1'b0;
    iresp_valid    = 1'b0;
    iresp_data     = 32'd0;
    d_ready        = 1'b0;
  endtask

  // Starts in REQ at address a, ends in HOLD with the returned word buffered.
  task automatic fetch_one(input logic [63:0] a, input logic [31:0] d);
    n_chk++; if (ireq_valid !== 1'b1) $display("FAIL fetch_req_vld @%h got %b exp 1", a, ireq_valid); else n_pass++;
    n_chk++; if (ireq_addr !== a) $display("FAIL fetch_req_addr got %h exp %h", ireq_addr, a); else n_pass++;
    ireq_ready = 1'b1;
    tick();
    ireq_ready = 1'b0;
    n_chk++; if (ireq_valid !== 1'b0 || f_valid !== 1'b0) $display("FAIL fetch_wait @%h got req=%b fv=%b exp 0 0", a, ireq_valid, f_valid); else n_pass++;
    iresp_valid = 1'b1;
    iresp_data  = d;
    tick();
    iresp_valid = 1'b0;
    n_chk++; if (f_valid !== 1'b1) $display("FAIL fetch_fvalid @%h got %b exp 1", a, f_valid); else n_pass++;
    n_chk++; if (f_pc !== a) $display("FAIL fetch_fpc got %h exp %h", f_pc, a); else n_pass++;
    n_chk++; if (f_instr !== d || f_exc !== 1'b0) $display("FAIL fetch_instr got %h/%b exp %h/0", f_instr, f_exc, d); else n_pass++;
  endtask

  task automatic consume();
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    n_chk++; if (f_valid !== 1'b0) $display("FAIL consume_fvalid got %b exp 0", f_valid); else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    tick(); tick();
    n_chk++; if (ireq_valid !== 1'b0) $display("FAIL reset_req_vld got %b exp 0", ireq_valid); else n_pass++;
    n_chk++; if (f_valid !== 1'b0) $display("FAIL reset_fvalid got %b exp 0", f_valid); else n_pass++;
    n_chk++; if (f_pc !== 64'h8000_0000) $display("FAIL reset_fpc got %h exp 80000000", f_pc); else n_pass++;
    n_chk++; if (pcplus4 !== 64'h8000_0004) $display("FAIL reset_pcplus4 got %h exp 80000004", pcplus4); else n_pass++;
    n_chk++; if (f_instr !== 32'd0 || f_exc !== 1'b0) $display("FAIL reset_buf got %h/%b exp 0/0", f_instr, f_exc); else n_pass++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_sequential();
    fetch_one(64'h8000_0000, 32'h0000_0013);
    consume();
    fetch_one(64'h8000_0004, 32'h0000_0013);
    consume();
    fetch_one(64'h8000_0008, 32'h00A0_0093);
  endtask

  task automatic test_decode_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (f_valid !== 1'b1 || f_pc !== 64'h8000_0008 || f_instr !== 32'h00A0_0093)
        $display("FAIL stall_hold[%0d] got %b %h %h exp 1 80000008 00a00093", i, f_valid, f_pc, f_instr); else n_pass++;
      n_chk++; if (ireq_valid !== 1'b0) $display("FAIL stall_noreq[%0d] got %b exp 0", i, ireq_valid); else n_pass++;
    end
    consume();
    n_chk++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_000C) $display("FAIL stall_next got %b %h exp 1 8000000c", ireq_valid, ireq_addr); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    fetch_one(64'h8000_000C, 32'h1111_1111);
    consume();
    n_chk++; if (ireq_addr !== 64'h8000_0010) $display("FAIL rw_addr got %h exp 80000010", ireq_addr); else n_pass++;
    ireq_ready = 1'b1;
    tick();
    ireq_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    iresp_valid    = 1'b1;
    iresp_data     = 32'hAAAA_AAAA;
    tick();
    iresp_valid = 1'b0;
    n_chk++; if (f_valid !== 1'b0) $display("FAIL rw_dropped got fv=%b instr=%h exp fv=0", f_valid, f_instr); else n_pass++;
    n_chk++; if (f_instr === 32'hAAAA_AAAA) $display("FAIL rw_stale_instr got %h exp not aaaaaaaa", f_instr); else n_pass++;
    fetch_one(64'h8000_0100, 32'h2222_2222);
    consume();
  endtask

  task automatic test_redirect_unaccepted();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0104) $display("FAIL ru_stable[%0d] got %b %h exp 1 80000104", i, ireq_valid, ireq_addr); else n_pass++;
      if (i == 1) ireq_ready = 1'b1;
      tick();
    end
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = 32'hBBBB_BBBB;
    tick();
    iresp_valid = 1'b0;
    n_chk++; if (f_valid !== 1'b0) $display("FAIL ru_dropped got %b exp 0", f_valid); else n_pass++;
    fetch_one(64'h8000_0200, 32'h3333_3333);
  endtask

  task automatic test_redirect_vs_dready();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    d_ready        = 1'b1;
    tick();
    redirect_valid = 1'b0;
    d_ready        = 1'b0;
    n_chk++; if (ireq_addr !== 64'h8000_0300) $display("FAIL rd_addr got %h exp 80000300", ireq_addr); else n_pass++;
    fetch_one(64'h8000_0300, 32'h4444_4444);
  endtask

  task automatic test_misaligned_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0402;
    tick();
    redirect_valid = 1'b0;
    n_chk++; if (ireq_valid !== 1'b0) $display("FAIL mis_noreq got %b exp 0", ireq_valid); else n_pass++;
    tick();
    n_chk++; if (f_valid !== 1'b1 || f_exc !== 1'b1) $display("FAIL mis_exc got fv=%b exc=%b exp 1 1", f_valid, f_exc); else n_pass++;
    n_chk++; if (f_instr !== 32'd0 || f_pc !== 64'h8000_0402) $display("FAIL mis_buf got %h %h exp 0 80000402", f_instr, f_pc); else n_pass++;
    n_chk++; if (ireq_valid !== 1'b0) $display("FAIL mis_noreq2 got %b exp 0", ireq_valid); else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n_chk++; if (pcplus4 !== 64'd0) $display("FAIL wrap_pcplus4 got %h exp 0", pcplus4); else n_pass++;
    fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 32'h5555_5555);
    consume();
    n_chk++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'd0) $display("FAIL wrap_addr got %b %h exp 1 0", ireq_valid, ireq_addr); else n_pass++;
  endtask

  task automatic test_reset_midway();
    ireq_ready = 1'b1;
    tick();
    ireq_ready = 1'b0;
    #2 resetn = 1'b0;
    #1;
    n_chk++; if (ireq_valid !== 1'b0 || f_valid !== 1'b0 || f_pc !== 64'h8000_0000)
      $display("FAIL midreset got %b %b %h exp 0 0 80000000", ireq_valid, f_valid, f_pc); else n_pass++;
    tick();
    resetn = 1'b1;
    tick();
    n_chk++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) $display("FAIL midreset_req got %b %h exp 1 80000000", ireq_valid, ireq_addr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_unaccepted();
    test_redirect_vs_dready();
    test_misaligned_wrap();
    test_reset_midway();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
